// File: rtl/fault_campaign_sequencer_if.sv
// rtl/fault_campaign_sequencer_if.sv - per-location result record handshake
interface fault_campaign_sequencer_if #(
  parameter int LOC_W = 7,
  parameter int CNT_W = 16
);
  logic             res_valid;
  logic             res_ready;
  logic [LOC_W-1:0] res_loc;
  logic [CNT_W-1:0] res_errors;

  modport master (output res_valid, res_loc, res_errors, input res_ready);
  modport slave  (input res_valid, res_loc, res_errors, output res_ready);
endinterface

// File: rtl/fault_campaign_sequencer.sv
// rtl/fault_campaign_sequencer.sv - exhaustive single-location fault-injection campaign sequencer
module fault_campaign_sequencer #(
  parameter int          NUM_INJ      = 105,
  parameter int          TV_WIDTH     = 8,
  parameter int          RES_WIDTH    = 8,
  parameter int          FLUSH_CYCLES = 32,
  parameter int          RUN_CYCLES   = 1024,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int          LOC_W        = (NUM_INJ > 1) ? $clog2(NUM_INJ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 inject_mode_i,
  output logic [TV_WIDTH-1:0]  test_vector_o,
  output logic [NUM_INJ-1:0]   injection_vector_o,
  input  logic [RES_WIDTH-1:0] result_faulty_i,
  input  logic [RES_WIDTH-1:0] result_golden_i,
  output logic                 busy_o,
  output logic                 done_o,
  fault_campaign_sequencer_if.master res
);

  localparam int CYC_MAX = (FLUSH_CYCLES > RUN_CYCLES) ? FLUSH_CYCLES : RUN_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_REPORT,
    S_DONE
  } state_e;

  state_e               state_q;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_d;
  logic [TV_WIDTH-1:0]  tv_q;
  logic [NUM_INJ-1:0]   inj_q;
  logic [NUM_INJ-1:0]   onehot_d;
  logic [LOC_W-1:0]     loc_q;
  logic [CYC_W-1:0]     cyc_q;
  logic [CNT_WIDTH-1:0] err_q;
  logic [CNT_WIDTH-1:0] err_d;
  logic                 mode_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 valid_q;
  logic                 mismatch;
  logic                 flush_end;
  logic                 run_end;
  logic                 last_loc;

  // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
  assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign onehot_d  = NUM_INJ'(1) << loc_q;
  assign mismatch  = (result_faulty_i != result_golden_i);
  assign err_d     = (&err_q) ? err_q : err_q + 1'b1;
  assign flush_end = (cyc_q == CYC_W'(FLUSH_CYCLES - 1));
  assign run_end   = (cyc_q == CYC_W'(RUN_CYCLES - 1));
  assign last_loc  = (loc_q == LOC_W'(NUM_INJ - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      lfsr_q  <= LFSR_SEED;
      tv_q    <= '0;
      inj_q   <= '0;
      loc_q   <= '0;
      cyc_q   <= '0;
      err_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        // Any pending record is dropped and no done pulse is produced
        state_q <= S_IDLE;
        inj_q   <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              lfsr_q  <= LFSR_SEED;
              tv_q    <= LFSR_SEED[TV_WIDTH-1:0];
              loc_q   <= '0;
              cyc_q   <= '0;
              mode_q  <= inject_mode_i;
              busy_q  <= 1'b1;
              state_q <= S_FLUSH;
            end
          end
          S_FLUSH: begin
            lfsr_q <= lfsr_d;
            tv_q   <= lfsr_d[TV_WIDTH-1:0];
            if (flush_end) begin
              cyc_q   <= '0;
              err_q   <= '0;
              inj_q   <= onehot_d;
              state_q <= S_RUN;
            end else begin
              cyc_q <= cyc_q + 1'b1;
            end
          end
          S_RUN: begin
            lfsr_q <= lfsr_d;
            tv_q   <= lfsr_d[TV_WIDTH-1:0];
            if (mismatch) begin
              err_q <= err_d;
            end
            if (run_end) begin
              inj_q   <= '0;
              valid_q <= 1'b1;
              state_q <= S_REPORT;
            end else begin
              cyc_q <= cyc_q + 1'b1;
              inj_q <= mode_q ? onehot_d : '0;
            end
          end
          S_REPORT: begin
            if (res.res_ready) begin
              valid_q <= 1'b0;
              if (last_loc) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                loc_q   <= loc_q + 1'b1;
                cyc_q   <= '0;
                state_q <= S_FLUSH;
              end
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            inj_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign test_vector_o      = tv_q;
  assign injection_vector_o = inj_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign res.res_valid      = valid_q;
  assign res.res_loc        = loc_q;
  assign res.res_errors     = err_q;

endmodule

// File: tb/tb_fault_campaign_sequencer.sv
// tb/tb_fault_campaign_sequencer.sv - directed vector bench for fault_campaign_sequencer
module tb_fault_campaign_sequencer;

  logic clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: 4 locations, 16-bit counter
  logic       start_a, abort_a, mode_a, fault_en;
  logic [7:0] tv_a, res_f_a, res_g_a;
  logic [3:0] inj_a;
  logic       busy_a, done_a;
  fault_campaign_sequencer_if #(.LOC_W(2), .CNT_W(16)) ra ();

  assign res_g_a = tv_a;
  assign res_f_a = tv_a ^ {7'b0, fault_en & inj_a[2]};

  fault_campaign_sequencer #(
    .NUM_INJ(4), .TV_WIDTH(8), .RES_WIDTH(8), .FLUSH_CYCLES(4),
    .RUN_CYCLES(16), .CNT_WIDTH(16), .LFSR_SEED(16'hACE1), .LOC_W(2)
  ) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .abort_i(abort_a),
    .inject_mode_i(mode_a), .test_vector_o(tv_a), .injection_vector_o(inj_a),
    .result_faulty_i(res_f_a), .result_golden_i(res_g_a),
    .busy_o(busy_a), .done_o(done_a), .res(ra)
  );

  // DUT B: 2 locations, 4-bit counter, permanent mismatch for saturation
  logic       start_b, abort_b;
  logic [7:0] tv_b, res_f_b;
  logic [1:0] inj_b;
  logic       busy_b, done_b;
  fault_campaign_sequencer_if #(.LOC_W(1), .CNT_W(4)) rb ();

  assign res_f_b = tv_b ^ 8'h01;

  fault_campaign_sequencer #(
    .NUM_INJ(2), .TV_WIDTH(8), .RES_WIDTH(8), .FLUSH_CYCLES(4),
    .RUN_CYCLES(40), .CNT_WIDTH(4), .LFSR_SEED(16'hACE1), .LOC_W(1)
  ) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
    .inject_mode_i(1'b1), .test_vector_o(tv_b), .injection_vector_o(inj_b),
    .result_faulty_i(res_f_b), .result_golden_i(tv_b),
    .busy_o(busy_b), .done_o(done_b), .res(rb)
  );

  typedef struct packed {
    logic             mode;
    logic             fault_en;
    logic [3:0][15:0] exp_err;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic run_a(input vec_t v, input int idx);
    int          nrec;
    int          ndone;
    bit          busy_bad;
    logic [1:0]  locs [4];
    logic [15:0] errs [4];
    for (int i = 0; i < 4; i++) begin
      locs[i] = 2'd3 - 2'(i);
      errs[i] = 16'hFFFF;
    end
    mode_a       = v.mode;
    fault_en     = v.fault_en;
    ra.res_ready = 1'b1;
    pulse_start_a();
    check($sformatf("v%0d_busy_after_start", idx), 32'(busy_a), 32'd1);
    nrec     = 0;
    ndone    = 0;
    busy_bad = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (ra.res_valid && ra.res_ready) begin
        if (nrec < 4) begin
          locs[nrec] = ra.res_loc;
          errs[nrec] = ra.res_errors;
        end
        nrec++;
      end
      if (!busy_a) busy_bad = 1'b1;
      if (done_a) begin
        ndone++;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    check($sformatf("v%0d_done_count", idx), 32'(ndone), 32'd1);
    check($sformatf("v%0d_busy_during", idx), 32'(busy_bad), 32'd0);
    check($sformatf("v%0d_busy_after_done", idx), 32'(busy_a), 32'd0);
    check($sformatf("v%0d_done_one_cycle", idx), 32'(done_a), 32'd0);
    check($sformatf("v%0d_records", idx), 32'(nrec), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("v%0d_loc%0d", idx, i), 32'(locs[i]), 32'(i));
      check($sformatf("v%0d_err%0d", idx, i), 32'(errs[i]), 32'(v.exp_err[i]));
    end
  endtask

  initial begin
    logic [7:0] tv0;
    bit         found;
    bit         bad;
    int         nrec_b;
    int         ndone_b;
    logic [3:0] errs_b [2];
    logic       locs_b [2];

    vecs[0] = '0;
    vecs[1] = '0;
    vecs[1].mode = 1'b1;
    vecs[2] = '0;
    vecs[2].mode = 1'b1;
    vecs[2].fault_en = 1'b1;
    vecs[2].exp_err[2] = 16'd16;
    vecs[3] = '0;
    vecs[3].fault_en = 1'b1;
    vecs[3].exp_err[2] = 16'd1;

    rst = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0; fault_en = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    ra.res_ready = 1'b0;
    rb.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_valid", 32'(ra.res_valid), 32'd0);
    check("rst_inj", 32'(inj_a), 32'd0);
    check("rst_tv", 32'(tv_a), 32'd0);
    check("rst_errors", 32'(ra.res_errors), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      run_a(vecs[k], k);
      repeat (2) @(negedge clk);
    end

    // Back-pressure at loc 2: record, LFSR and injection must hold
    mode_a = 1'b1;
    fault_en = 1'b1;
    ra.res_ready = 1'b0;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (ra.res_valid) begin
        if (ra.res_loc == 2'd2) begin
          found = 1'b1;
        end else begin
          ra.res_ready = 1'b1;
          @(negedge clk);
          ra.res_ready = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
    check("stall_reached_loc2", 32'(found), 32'd1);
    tv0 = tv_a;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("stall%0d_valid", k), 32'(ra.res_valid), 32'd1);
      check($sformatf("stall%0d_loc", k), 32'(ra.res_loc), 32'd2);
      check($sformatf("stall%0d_err", k), 32'(ra.res_errors), 32'd16);
      check($sformatf("stall%0d_tv", k), 32'(tv_a), 32'(tv0));
      check($sformatf("stall%0d_inj", k), 32'(inj_a), 32'd0);
      @(negedge clk);
    end
    ra.res_ready = 1'b1;
    @(negedge clk);
    check("stall_valid_drop", 32'(ra.res_valid), 32'd0);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (done_a) found = 1'b1;
      else @(negedge clk);
    end
    check("stall_done", 32'(found), 32'd1);
    repeat (2) @(negedge clk);

    // Abort mid-RUN at loc 1
    fault_en = 1'b0;
    mode_a = 1'b1;
    ra.res_ready = 1'b1;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (inj_a == 4'b0010) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reached_loc1", 32'(found), 32'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_inj", 32'(inj_a), 32'd0);
    check("abort_valid", 32'(ra.res_valid), 32'd0);
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done_a || busy_a) bad = 1'b1;
      @(negedge clk);
    end
    check("abort_no_done", 32'(bad), 32'd0);
    pulse_start_a();
    check("restart_tv_seed", 32'(tv_a), 32'h0000_00E1);
    check("restart_busy", 32'(busy_a), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (ra.res_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("restart_first_record", 32'(found), 32'd1);
    check("restart_loc0", 32'(ra.res_loc), 32'd0);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("start_abort_idle", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("start_abort_idle2", 32'(busy_a), 32'd0);

    // Saturating counter on DUT B
    rb.res_ready = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nrec_b = 0;
    ndone_b = 0;
    errs_b[0] = 4'h0; errs_b[1] = 4'h0;
    locs_b[0] = 1'b1; locs_b[1] = 1'b0;
    for (int c = 0; c < 400 && ndone_b == 0; c++) begin
      if (rb.res_valid) begin
        if (nrec_b < 2) begin
          errs_b[nrec_b] = rb.res_errors;
          locs_b[nrec_b] = rb.res_loc;
        end
        nrec_b++;
      end
      if (done_b) ndone_b++;
      @(negedge clk);
    end
    check("sat_done", 32'(ndone_b), 32'd1);
    check("sat_records", 32'(nrec_b), 32'd2);
    check("sat_loc0", 32'(locs_b[0]), 32'd0);
    check("sat_loc1", 32'(locs_b[1]), 32'd1);
    check("sat_err0", 32'(errs_b[0]), 32'd15);
    check("sat_err1", 32'(errs_b[1]), 32'd15);

    // Asynchronous reset while a record is pending
    mode_a = 1'b0;
    ra.res_ready = 1'b0;
    pulse_start_a();
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (ra.res_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("rstmid_record_pending", 32'(found), 32'd1);
    #2;
    rst = 1'b0;
    start_a = 1'b1;
    #1;
    check("rstmid_valid_async", 32'(ra.res_valid), 32'd0);
    check("rstmid_busy_async", 32'(busy_a), 32'd0);
    @(negedge clk);
    start_a = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 32'(busy_a), 32'd0);
    check("rstmid_valid", 32'(ra.res_valid), 32'd0);
    check("rstmid_done", 32'(done_a), 32'd0);
    check("rstmid_inj", 32'(inj_a), 32'd0);
    check("rstmid_tv", 32'(tv_a), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fault_campaign_sequencer.md
Name: fault_campaign_sequencer

Overview:
Sequences an exhaustive single-location fault-injection campaign on the circuit under test. For each injection location it does the following:
- Flushes the pipelines fault-free.
- Drives a one-hot injection vector while feeding pseudo-random test vectors from an internal LFSR.
- Counts cycles where the faulty instance's result differs from a fault-free golden instance's result.
- Reports one record per location over a valid/ready interface.

It sits between the AXI register wrapper (start/abort/readout) and the circuit_under_test pair (faulty + golden).

Parameters:
NUM_INJ, 105, number of injection locations (injection vector width)
TV_WIDTH, 8, test vector width
RES_WIDTH, 8, result vector width
FLUSH_CYCLES, 32, fault-free cycles before each location's run (>= CUT pipeline depth)
RUN_CYCLES, 1024, compare cycles per location
CNT_WIDTH, 16, error counter width
LFSR_SEED, 16'hACE1, LFSR value loaded at start

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins campaign, honoured only in IDLE
abort  in  1  level; forces return to IDLE
inject_mode  in  1  sampled at start: 0 = transient (first RUN cycle only), 1 = permanent (all RUN cycles)
test_vector  out  TV_WIDTH  stimulus to both CUT instances (LFSR[TV_WIDTH-1:0])
injection_vector  out  NUM_INJ  to faulty CUT instance
result_faulty  in  RES_WIDTH  faulty instance resultVector
result_golden  in  RES_WIDTH  golden instance resultVector
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse on DONE->IDLE
res_valid  out  1  record valid
res_ready  in  1  consumer accepts record
res_loc  out  7 (clog2 NUM_INJ)  location index of record
res_errors  out  CNT_WIDTH  mismatch count, saturating

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, all outputs 0.
  - loc=0, counters 0, LFSR=LFSR_SEED.
- States: IDLE, FLUSH, RUN, REPORT, DONE.
- IDLE:
  - injection_vector=0; LFSR holds.
  - On start: LFSR<=LFSR_SEED, loc<=0, latch inject_mode, go FLUSH.
- FLUSH:
  - injection_vector=0; LFSR advances every cycle.
  - Cycle counter counts FLUSH_CYCLES cycles, then go RUN with cycle counter=0 and err=0.
- RUN:
  - LFSR advances every cycle.
  - injection_vector = (1<<loc) in every RUN cycle if permanent mode; transient mode drives it only on RUN cycle 0, zero otherwise.
  - Each cycle, if result_faulty != result_golden: err<=err+1, saturating at 2^CNT_WIDTH-1.
  - After RUN_CYCLES cycles go REPORT.
  - The faulty result lags injection by the CUT pipeline depth. Faults that propagate beyond the last RUN cycle are dropped by design; the next FLUSH clears them.
- REPORT:
  - injection_vector=0; LFSR holds.
  - res_valid=1 with res_loc=loc and res_errors=err, held stable until res_valid&res_ready.
  - On handshake: if loc==NUM_INJ-1 go DONE, else loc<=loc+1 and go FLUSH.
  - res_valid deasserts the cycle after the handshake.
- DONE: done=1 for one cycle, then IDLE.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0. It never reaches zero because the seed is nonzero.
- abort=1 in any state:
  - Next state is IDLE.
  - injection_vector=0 and res_valid=0 registered the same edge.
  - done not pulsed.
  - abort has priority over start and over a concurrent res handshake, and the record is discarded.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: stays IDLE.
- Reset mid-campaign: immediate IDLE, no record or done emitted.
- All outputs are registered; injection_vector and test_vector change only on clk edges.

Test Plan:
- Golden==faulty tied together, NUM_INJ=4, RUN_CYCLES=16, FLUSH_CYCLES=4, start -> 4 records, loc 0..3, each res_errors=0; done pulses once; busy high from the cycle after start until the cycle after done.
- result_faulty = golden ^ {7'b0, injection_vector[2]}, permanent mode -> loc2 reports 16, all other locations report 0; transient mode -> loc2 reports 1.
- res_ready held low 10 cycles in REPORT -> res_valid, res_loc and res_errors stable for all 10 cycles; LFSR unchanged; injection_vector=0.
- CNT_WIDTH=4, constant mismatch, RUN_CYCLES=40 -> res_errors=15 (saturated, no wrap).
- abort asserted mid-RUN at loc 1 -> IDLE next cycle, injection_vector=0, no done. A subsequent start restarts at loc 0, and test_vector on its first FLUSH cycle equals LFSR_SEED[7:0]=8'hE1.
- rst pulled low during REPORT with res_valid=1 -> res_valid=0 and busy=0 immediately (asynchronously); start pulse ignored while rst is low.
